dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single data memory (DM) between NUM_CORES processing cores in the multi-core multiplier.
- Each core issues a load/store request; the arbiter serialises them, drives the DM port, and returns read data plus a one-cycle completion strobe.
- Read data is the value each core subsequently places on its own bus through the dm source.
- Sits between the per-core control units and the shared DM block RAM, which has a synchronous read with 1-cycle latency.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..8).
- ADDR_W, 8, DM address width.
- DATA_W, 8, DM data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- core_req  in  NUM_CORES  per-core request; held high until that core's done pulse.
- core_we  in  NUM_CORES  per-core write enable (1=store, 0=load); qualified by core_req.
- core_addr  in  NUM_CORES*ADDR_W  flattened addresses; core i occupies bits [i*ADDR_W +: ADDR_W].
- core_wdata  in  NUM_CORES*DATA_W  flattened store data, same packing.
- core_grant  out  NUM_CORES  one-hot; high for the owning core from ISSUE through DONE.
- core_done  out  NUM_CORES  one-cycle pulse to the owning core in DONE.
- core_rdata  out  DATA_W  shared load-data register; valid while core_done is high.
- mem_en  out  1  DM access enable.
- mem_we  out  1  DM write strobe.
- mem_addr  out  ADDR_W  DM address.
- mem_wdata  out  DATA_W  DM write data.
- mem_rdata  in  DATA_W  DM read data, valid 1 cycle after mem_en with mem_we=0.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values (asynchronous):
  - state=IDLE.
  - rr_ptr=NUM_CORES-1, so core 0 has first priority.
  - All outputs 0, including core_rdata, mem_addr and mem_wdata.
- FSM: IDLE -> ISSUE -> WAIT -> DONE -> IDLE. Every non-IDLE state lasts exactly 1 cycle.
- IDLE:
  - If any core_req bit is set, select the first requesting index scanning from rr_ptr+1 upward, wrapping modulo NUM_CORES.
  - Latch that core's index, we, addr and wdata into internal registers, then go to ISSUE.
  - If no request is set, stay in IDLE.
- ISSUE:
  - mem_en=1; mem_we=latched we; mem_addr and mem_wdata from the latched values.
  - core_grant[idx]=1.
- WAIT:
  - mem_en=0, mem_we=0; core_grant is held.
  - On the clock edge ending WAIT, if the transaction is a load, core_rdata <= mem_rdata.
- DONE:
  - core_done[idx]=1 and core_grant[idx]=1.
  - rr_ptr <= idx; next state is IDLE.
- Latency:
  - A request sampled in IDLE at cycle T produces its done pulse in cycle T+3.
  - The earliest next grant is issued at T+5 (IDLE sampled at T+4).
  - Sustained throughput is one access per 4 cycles.
- Stores:
  - core_rdata is left unchanged.
  - mem_we is high for exactly one cycle, in ISSUE.
- core_rdata holds its value until the next load completes.
- Request inputs are sampled only in IDLE. Changes to core_we, core_addr or core_wdata after latching have no effect on the transaction in flight.
- If a core drops core_req mid-transaction, the transaction still completes and core_done still pulses.
- If a core keeps core_req high in the IDLE cycle after its done pulse, that is treated as a new request. Round-robin order still applies, so other pending cores win first.
- Simultaneous requests: exactly one grant is issued per transaction. Fairness bound: a continuously requesting core waits at most NUM_CORES-1 transactions.
- Reset asserted mid-transaction:
  - Immediate return to IDLE with all outputs 0.
  - Any pending mem write already issued is not retracted.
  - No done pulse is generated.
- core_grant and core_done are never multi-hot. core_done is never high outside DONE.
- All outputs are registered or decoded from state only; there is no combinational path from the core_* inputs to any output.

Test Plan:
- Reset then idle: rst pulse, core_req=0 for 10 cycles -> busy=0, mem_en=0, all grants and done flags 0, core_rdata=0.
- Single load: DM[0x12]=0xA5; core 1 req with we=0 and addr=0x12 at T.
  - mem_en=1 with mem_addr=0x12 at T+1.
  - core_done=4'b0010 and core_rdata=0xA5 at T+3.
- Single store then load: core 2 stores 0x3C to 0x40, then core 0 loads 0x40.
  - mem_we pulses once with mem_wdata=0x3C.
  - core_rdata remains at its prior value after the store; the load then returns 0x3C.
- Round-robin contention: after reset all 4 cores hold req continuously.
  - Grant order is 0,1,2,3,0, with done pulses 4 cycles apart.
  - Each core's done pulse is one-hot.
- Request drop and reset mid-op:
  - Core 3 drops req in WAIT -> core_done[3] still pulses.
  - Separately, rst asserted in WAIT -> outputs 0 immediately and no done pulse; after release, core 0 is granted first.

Source files
------------

// File: rtl/dm_arbiter.sv
// Round-robin arbiter that serialises per-core load/store requests onto the single
// shared data-memory port and returns load data with a one-cycle completion strobe.
module dm_arbiter #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CORES-1:0]        core_req,
    input  logic [NUM_CORES-1:0]        core_we,
    input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
    input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
    output logic [NUM_CORES-1:0]        core_grant,
    output logic [NUM_CORES-1:0]        core_done,
    output logic [DATA_W-1:0]           core_rdata,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic                        busy
);

    localparam int unsigned IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   we_q, we_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic [NUM_CORES-1:0]   grant_q, grant_d;
    logic [NUM_CORES-1:0]   done_q, done_d;
    logic                   mem_en_q, mem_en_d;
    logic                   mem_we_q, mem_we_d;
    logic                   busy_q, busy_d;

    logic [IDX_W-1:0]       sel_idx, cand_idx;
    logic                   sel_found;

    // Scan from the core after the last winner, wrapping, so the last winner is lowest priority.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand_idx  = '0;
        for (int k = 1; k <= int'(NUM_CORES); k++) begin
            cand_idx = IDX_W'((int'(rr_ptr_q) + k) % int'(NUM_CORES));
            if (!sel_found && core_req[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        idx_d    = idx_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;

        unique case (state_q)
            StIdle: begin
                if (sel_found) begin
                    idx_d   = sel_idx;
                    we_d    = core_we[sel_idx];
                    addr_d  = core_addr[sel_idx*ADDR_W +: ADDR_W];
                    wdata_d = core_wdata[sel_idx*DATA_W +: DATA_W];
                    state_d = StIssue;
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                // DM read data arrives one cycle after the ISSUE access.
                if (!we_q) begin
                    rdata_d = mem_rdata;
                end
                state_d = StDone;
            end
            StDone: begin
                rr_ptr_d = idx_q;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered: derive them from the next state and next latched values.
        busy_d   = (state_d != StIdle);
        mem_en_d = (state_d == StIssue);
        mem_we_d = (state_d == StIssue) && we_d;
        grant_d  = busy_d ? (NUM_CORES'(1) << idx_d) : '0;
        done_d   = (state_d == StDone) ? (NUM_CORES'(1) << idx_d) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            rr_ptr_q <= IDX_W'(NUM_CORES - 1);
            idx_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            idx_q    <= idx_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            mem_en_q <= mem_en_d;
            mem_we_q <= mem_we_d;
            busy_q   <= busy_d;
        end
    end

    assign core_grant = grant_q;
    assign core_done  = done_q;
    assign core_rdata = rdata_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed vector table, hand sequences for reset and
// contention, and randomized traffic against a transaction-level reference model.
module tb_dm_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  core_req = '0;
    logic [N-1:0]  core_we = '0;
    logic [N*8-1:0] core_addr = '0;
    logic [N*8-1:0] core_wdata = '0;
    logic [N-1:0]  core_grant, core_done;
    logic [7:0]    core_rdata;
    logic          mem_en, mem_we;
    logic [7:0]    mem_addr, mem_wdata;
    logic [7:0]    mem_rdata;
    logic          busy;

    logic [7:0]    dm [256];
    logic          mem_init = 1'b0;
    logic          pre_we = 1'b0;
    logic [7:0]    pre_addr = '0;
    logic [7:0]    pre_data = '0;

    int n_checks = 0;
    int n_pass = 0;

    dm_arbiter #(.NUM_CORES(N), .ADDR_W(8), .DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_grant (core_grant),
        .core_done  (core_done),
        .core_rdata (core_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Shared DM block RAM with 1-cycle synchronous read.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) dm[i] <= 8'(i) ^ 8'h5A;
        end else if (pre_we) begin
            dm[pre_addr] <= pre_data;
        end
        if (mem_en) begin
            if (mem_we) dm[mem_addr] <= mem_wdata;
            else        mem_rdata <= dm[mem_addr];
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic set_core(input int c, input logic r, input logic w, input logic [7:0] a,
                            input logic [7:0] d);
        core_req[c]           = r;
        core_we[c]            = w;
        core_addr[c*8 +: 8]   = a;
        core_wdata[c*8 +: 8]  = d;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        core_req = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Ticks until a done pulse is seen; an expired budget counts as a failed check.
    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (cycles < budget) begin
            tick();
            cycles++;
            if (core_done != '0) return;
        end
        check("done_timeout", 32'(cycles), 32'(budget + 1));
    endtask

    typedef struct {
        int         core;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs [4];

    // Reference model state, transaction level.
    int         m_age;
    int         m_idx;
    int         m_last;
    logic       m_we;
    logic [7:0] m_addr, m_wdata, m_rdata;
    logic [7:0] ref_mem [256];

    initial begin
        int cyc;
        int c;
        logic found;

        // Reset then idle.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_busy", 32'(busy), 32'(0));
            check("idle_mem_en", 32'(mem_en), 32'(0));
            check("idle_grant", 32'(core_grant), 32'(0));
            check("idle_done", 32'(core_done), 32'(0));
            check("idle_rdata", 32'(core_rdata), 32'(0));
        end
        check("idle_mem_addr", 32'(mem_addr), 32'(0));
        check("idle_mem_wdata", 32'(mem_wdata), 32'(0));
        check("idle_mem_we", 32'(mem_we), 32'(0));

        pre_we = 1'b1; pre_addr = 8'h12; pre_data = 8'hA5;
        tick();
        pre_we = 1'b0;

        // Directed transactions: load, store, load-back, store (rdata unchanged).
        vecs[0] = '{core: 1, we: 1'b0, addr: 8'h12, wdata: 8'h00, exp_rdata: 8'hA5};
        vecs[1] = '{core: 2, we: 1'b1, addr: 8'h40, wdata: 8'h3C, exp_rdata: 8'hA5};
        vecs[2] = '{core: 0, we: 1'b0, addr: 8'h40, wdata: 8'h00, exp_rdata: 8'h3C};
        vecs[3] = '{core: 3, we: 1'b1, addr: 8'h41, wdata: 8'h77, exp_rdata: 8'h3C};
        foreach (vecs[v]) begin
            set_core(vecs[v].core, 1'b1, vecs[v].we, vecs[v].addr, vecs[v].wdata);
            tick();
            check("vec_issue_en", 32'(mem_en), 32'(1));
            check("vec_issue_addr", 32'(mem_addr), 32'(vecs[v].addr));
            check("vec_issue_we", 32'(mem_we), 32'(vecs[v].we));
            check("vec_issue_grant", 32'(core_grant), 32'(1) << vecs[v].core);
            if (vecs[v].we) check("vec_issue_wdata", 32'(mem_wdata), 32'(vecs[v].wdata));
            tick();
            check("vec_wait_en", 32'(mem_en), 32'(0));
            check("vec_wait_we", 32'(mem_we), 32'(0));
            check("vec_wait_grant", 32'(core_grant), 32'(1) << vecs[v].core);
            tick();
            check("vec_done", 32'(core_done), 32'(1) << vecs[v].core);
            check("vec_rdata", 32'(core_rdata), 32'(vecs[v].exp_rdata));
            set_core(vecs[v].core, 1'b0, 1'b0, 8'h00, 8'h00);
            tick();
            check("vec_idle_done", 32'(core_done), 32'(0));
            check("vec_idle_busy", 32'(busy), 32'(0));
        end

        // Round-robin contention from reset: order 0,1,2,3,0 with 4-cycle spacing.
        do_reset();
        for (int i = 0; i < N; i++) set_core(i, 1'b1, 1'b0, 8'h12, 8'h00);
        for (int k = 0; k < 5; k++) begin
            wait_done(8, cyc);
            check("rr_order", 32'(core_done), 32'(1) << (k % N));
            check("rr_gap", 32'(cyc), (k == 0) ? 32'(3) : 32'(4));
        end
        core_req = '0;
        for (int i = 0; i < 5; i++) tick();
        check("rr_drain_busy", 32'(busy), 32'(0));

        // Core 3 drops its request during WAIT; the transaction still completes.
        do_reset();
        set_core(3, 1'b1, 1'b0, 8'h12, 8'h00);
        tick();
        check("drop_grant", 32'(core_grant), 32'h8);
        tick();
        core_req[3] = 1'b0;
        tick();
        check("drop_done", 32'(core_done), 32'h8);
        check("drop_rdata", 32'(core_rdata), 32'hA5);
        tick();

        // Reset asserted during WAIT.
        set_core(1, 1'b1, 1'b0, 8'h12, 8'h00);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_grant", 32'(core_grant), 32'(0));
        check("rst_mem_en", 32'(mem_en), 32'(0));
        check("rst_rdata", 32'(core_rdata), 32'(0));
        for (int i = 0; i < N; i++) set_core(i, 1'b1, 1'b0, 8'h20, 8'h00);
        tick();
        check("rst_no_done", 32'(core_done), 32'(0));
        tick();
        rst = 1'b0;
        tick();
        check("rst_first_grant", 32'(core_grant), 32'h1);
        core_req = '0;
        for (int i = 0; i < 4; i++) tick();

        // Randomized traffic against the reference model.
        rst = 1'b1;
        mem_init = 1'b1;
        tick();
        mem_init = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
        m_age = 0; m_last = N - 1; m_rdata = 8'h00; m_idx = 0;
        m_we = 1'b0; m_addr = 8'h00; m_wdata = 8'h00;
        for (int t = 0; t < 1200; t++) begin
            // Driver: owner may re-request after done; others raise requests at random.
            if (m_age == 3) begin
                if ($urandom_range(0, 1) == 1)
                    set_core(m_idx, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
                             8'($urandom));
                else
                    core_req[m_idx] = 1'b0;
            end
            if (m_age == 1 || m_age == 2) begin
                set_core(m_idx, ($urandom_range(0, 7) != 0) && core_req[m_idx],
                         1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            end
            for (int i = 0; i < N; i++) begin
                if (!core_req[i] && !(m_age != 0 && i == m_idx) && $urandom_range(0, 3) == 0)
                    set_core(i, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
                             8'($urandom));
            end

            // Model: one transaction at a time, 4 cycles each, winner by rotating priority.
            case (m_age)
                0: begin
                    found = 1'b0;
                    for (int k = 1; k <= N; k++) begin
                        c = (m_last + k) % N;
                        if (!found && core_req[c]) begin
                            found   = 1'b1;
                            m_idx   = c;
                            m_we    = core_we[c];
                            m_addr  = core_addr[c*8 +: 8];
                            m_wdata = core_wdata[c*8 +: 8];
                        end
                    end
                    if (found) m_age = 1;
                end
                1: begin
                    if (m_we) ref_mem[m_addr] = m_wdata;
                    m_age = 2;
                end
                2: begin
                    if (!m_we) m_rdata = ref_mem[m_addr];
                    m_age = 3;
                end
                default: begin
                    m_last = m_idx;
                    m_age  = 0;
                end
            endcase

            tick();
            check("rnd_busy", 32'(busy), 32'(m_age != 0));
            check("rnd_mem_en", 32'(mem_en), 32'(m_age == 1));
            check("rnd_mem_we", 32'(mem_we), 32'(m_age == 1 && m_we));
            check("rnd_grant", 32'(core_grant), (m_age != 0) ? (32'(1) << m_idx) : 32'(0));
            check("rnd_done", 32'(core_done), (m_age == 3) ? (32'(1) << m_idx) : 32'(0));
            check("rnd_rdata", 32'(core_rdata), 32'(m_rdata));
            if (m_age == 1) begin
                check("rnd_mem_addr", 32'(mem_addr), 32'(m_addr));
                if (m_we) check("rnd_mem_wdata", 32'(mem_wdata), 32'(m_wdata));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
